// File: rtl/delay_tdc_sampler.sv
// delay_tdc_sampler: drives an external tapped delay chain, samples the tap
// vector once per launch, thermometer-encodes it and reports the average,
// minimum and maximum code over 2^SAMP_LOG2 launches on a valid/ready port.
// A free-running cycle counter with enable and clear is carried alongside.
module delay_tdc_sampler #(
    parameter int TAPS      = 64,
    parameter int SAMP_LOG2 = 2,
    parameter int SETTLE    = 1,
    parameter int CNT_W     = 32,
    localparam int CODE_W   = $clog2(TAPS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              launch,
    input  logic [TAPS-1:0]   taps,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CODE_W-1:0] m_avg,
    output logic [CODE_W-1:0] m_min,
    output logic [CODE_W-1:0] m_max,
    output logic              m_ovf,
    input  logic              cnt_en,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cycles
);

    // Sum of 2^SAMP_LOG2 codes, each at most TAPS, cannot exceed this width.
    localparam int ACC_W = CODE_W + SAMP_LOG2;
    // Sample counter must hold 0 .. 2^SAMP_LOG2 - 1.
    localparam int N_W   = SAMP_LOG2 + 1;
    localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [N_W-1:0]    N_LAST     = N_W'((1 << SAMP_LOG2) - 1);
    localparam logic [SET_W-1:0]  SET_LAST   = SET_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam logic [CODE_W-1:0] CODE_SAT   = CODE_W'(TAPS);
    localparam logic [CODE_W-1:0] CODE_ONES  = {CODE_W{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_SYNC1  = 3'd2,
        ST_SYNC2  = 3'd3,
        ST_ENC    = 3'd4,
        ST_DRAIN  = 3'd5,
        ST_DONE   = 3'd6
    } state_t;

    // Index of the lowest zero tap; TAPS when every tap is one. Ones above
    // the first zero are bubbles from uneven stage delays and are ignored.
    function automatic logic [CODE_W-1:0] therm_code(input logic [TAPS-1:0] v);
        logic [CODE_W-1:0] c;
        logic              found;
        c     = CODE_SAT;
        found = 1'b0;
        for (int i = 0; i < TAPS; i++) begin
            if (!found && !v[i]) begin
                c     = CODE_W'(i);
                found = 1'b1;
            end else begin
                c     = c;
            end
        end
        return c;
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic                launch_r;
    logic                busy_r;
    logic                m_valid_r;
    logic [TAPS-1:0]     r0_r;
    logic [TAPS-1:0]     r1_r;
    logic [TAPS-1:0]     r2_r;
    logic [ACC_W-1:0]    acc_r;
    logic [CODE_W-1:0]   min_r;
    logic [CODE_W-1:0]   max_r;
    logic                ovf_r;
    logic [N_W-1:0]      n_r;
    logic [SET_W-1:0]    settle_r;
    logic [CODE_W-1:0]   m_avg_r;
    logic [CODE_W-1:0]   m_min_r;
    logic [CODE_W-1:0]   m_max_r;
    logic                m_ovf_r;
    logic [CNT_W-1:0]    cycles_r;

    logic [CODE_W-1:0]   code_s;
    logic [ACC_W-1:0]    acc_sum_s;
    logic [ACC_W-1:0]    avg_full_s;
    logic [CODE_W-1:0]   min_upd_s;
    logic [CODE_W-1:0]   max_upd_s;
    logic                ovf_upd_s;

    // Encode the synchronised tap vector and form the updated statistics.
    always_comb begin
        code_s     = therm_code(r2_r);
        acc_sum_s  = acc_r + ACC_W'(code_s);
        avg_full_s = acc_sum_s >> SAMP_LOG2;
        if (code_s < min_r) begin
            min_upd_s = code_s;
        end else begin
            min_upd_s = min_r;
        end
        if (code_s > max_r) begin
            max_upd_s = code_s;
        end else begin
            max_upd_s = max_r;
        end
        ovf_upd_s = ovf_r | (code_s == CODE_SAT);
    end

    // Next-state decision for the measurement sequencer.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_LAUNCH;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_LAUNCH: state_nx_s = ST_SYNC1;
            ST_SYNC1:  state_nx_s = ST_SYNC2;
            ST_SYNC2:  state_nx_s = ST_ENC;
            ST_ENC: begin
                if (n_r == N_LAST) begin
                    state_nx_s = ST_DONE;
                end else if (SETTLE == 0) begin
                    state_nx_s = ST_LAUNCH;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (settle_r == SET_LAST) begin
                    state_nx_s = ST_LAUNCH;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (m_ready) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and registered control outputs decoded from next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            launch_r  <= 1'b0;
            busy_r    <= 1'b0;
            m_valid_r <= 1'b0;
        end else begin
            state_r   <= state_nx_s;
            launch_r  <= (state_nx_s == ST_LAUNCH);
            busy_r    <= (state_nx_s != ST_IDLE);
            m_valid_r <= (state_nx_s == ST_DONE);
        end
    end

    // Free-running capture and two-stage synchroniser for the chain taps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r0_r <= '0;
            r1_r <= '0;
            r2_r <= '0;
        end else begin
            r0_r <= taps;
            r1_r <= r0_r;
            r2_r <= r1_r;
        end
    end

    // Per-measurement statistics: cleared on start, updated once per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
            min_r <= '0;
            max_r <= '0;
            ovf_r <= 1'b0;
            n_r   <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        acc_r <= '0;
                        min_r <= CODE_ONES;
                        max_r <= '0;
                        ovf_r <= 1'b0;
                        n_r   <= '0;
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_ENC: begin
                    acc_r <= acc_sum_s;
                    min_r <= min_upd_s;
                    max_r <= max_upd_s;
                    ovf_r <= ovf_upd_s;
                    n_r   <= n_r + N_W'(1);
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // Drain-cycle counter between a sample's encode and the next launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_r <= '0;
        end else if (state_r == ST_DRAIN) begin
            settle_r <= settle_r + SET_W'(1);
        end else begin
            settle_r <= '0;
        end
    end

    // Result registers, loaded only on the transition into DONE and then held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_avg_r <= '0;
            m_min_r <= '0;
            m_max_r <= '0;
            m_ovf_r <= 1'b0;
        end else if ((state_r == ST_ENC) && (n_r == N_LAST)) begin
            m_avg_r <= avg_full_s[CODE_W-1:0];
            m_min_r <= min_upd_s;
            m_max_r <= max_upd_s;
            m_ovf_r <= ovf_upd_s;
        end else begin
            m_avg_r <= m_avg_r;
        end
    end

    // Cycle counter, independent of the sequencer; clear wins over enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycles_r <= '0;
        end else if (cnt_clr) begin
            cycles_r <= '0;
        end else if (cnt_en) begin
            cycles_r <= cycles_r + CNT_W'(1);
        end else begin
            cycles_r <= cycles_r;
        end
    end

    assign busy    = busy_r;
    assign launch  = launch_r;
    assign m_valid = m_valid_r;
    assign m_avg   = m_avg_r;
    assign m_min   = m_min_r;
    assign m_max   = m_max_r;
    assign m_ovf   = m_ovf_r;
    assign cycles  = cycles_r;

endmodule

// File: tb/tb_delay_tdc_sampler.sv
// Scoreboard bench for delay_tdc_sampler: a default instance (4 samples,
// SETTLE=1) and a single-sample instance with an 8-bit cycle counter.
module tb_delay_tdc_sampler;

    typedef struct {
        int avg;
        int mn;
        int mx;
        int ovf;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          tb_cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    // default instance
    logic        start = 1'b0, m_ready = 1'b1, cnt_en = 1'b0, cnt_clr = 1'b0;
    logic [63:0] taps = '0, taps_const = '0;
    logic        busy, launch, m_valid, m_ovf;
    logic [6:0]  m_avg, m_min, m_max;
    logic [31:0] cycles;

    // single-sample instance
    logic        start1 = 1'b0, m_ready1 = 1'b1, cnt_en1 = 1'b0, cnt_clr1 = 1'b0;
    logic [63:0] taps1 = '0;
    logic        busy1, launch1, m_valid1, m_ovf1;
    logic [6:0]  m_avg1, m_min1, m_max1;
    logic [7:0]  cycles1;

    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [63:0] tap_q[$];
    int          start_cyc = 0, start_cyc1 = 0;
    int          launch_cnt = 0, wide_cnt = 0;

    delay_tdc_sampler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .launch(launch),
        .taps(taps), .m_valid(m_valid), .m_ready(m_ready), .m_avg(m_avg),
        .m_min(m_min), .m_max(m_max), .m_ovf(m_ovf), .cnt_en(cnt_en),
        .cnt_clr(cnt_clr), .cycles(cycles)
    );

    delay_tdc_sampler #(.SAMP_LOG2(0), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .launch(launch1),
        .taps(taps1), .m_valid(m_valid1), .m_ready(m_ready1), .m_avg(m_avg1),
        .m_min(m_min1), .m_max(m_max1), .m_ovf(m_ovf1), .cnt_en(cnt_en1),
        .cnt_clr(cnt_clr1), .cycles(cycles1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc <= tb_cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Chain model: a new tap pattern is presented for each launch pulse.
    initial begin
        bit lp;
        lp = 1'b0;
        forever begin
            @(negedge clk);
            if (launch && tap_q.size() > 0) taps = tap_q.pop_front();
            else if (!launch) taps = taps_const;
            if (launch) begin
                launch_cnt++;
                if (lp) wide_cnt++;
            end
            lp = launch;
        end
    end

    // Monitor for the default instance.
    initial begin
        bit   vp;
        exp_t e;
        vp = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid && !vp) begin
                if (sb0.size() == 0) check("unexpected_valid0", 64'd1, 64'd0);
                else check("latency0", 64'(tb_cyc - start_cyc), 64'(sb0[0].lat));
            end
            if (m_valid && m_ready && sb0.size() > 0) begin
                e = sb0.pop_front();
                check("avg0", 64'(m_avg), 64'(e.avg));
                check("min0", 64'(m_min), 64'(e.mn));
                check("max0", 64'(m_max), 64'(e.mx));
                check("ovf0", 64'(m_ovf), 64'(e.ovf));
            end
            vp = m_valid;
        end
    end

    // Monitor for the single-sample instance.
    initial begin
        bit   vp;
        exp_t e;
        vp = 1'b0;
        forever begin
            @(negedge clk);
            if (m_valid1 && !vp) begin
                if (sb1.size() == 0) check("unexpected_valid1", 64'd1, 64'd0);
                else check("latency1", 64'(tb_cyc - start_cyc1), 64'(sb1[0].lat));
            end
            if (m_valid1 && m_ready1 && sb1.size() > 0) begin
                e = sb1.pop_front();
                check("avg1", 64'(m_avg1), 64'(e.avg));
                check("min1", 64'(m_min1), 64'(e.mn));
                check("max1", 64'(m_max1), 64'(e.mx));
                check("ovf1", 64'(m_ovf1), 64'(e.ovf));
            end
            vp = m_valid1;
        end
    end

    task automatic pulse_start(input exp_t e);
        sb0.push_back(e);
        start     = 1'b1;
        start_cyc = tb_cyc + 1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 200; i++) begin
            if (!busy && !busy1) break;
            tick();
        end
        if (i == 200) check({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic run_meas(input string name, input exp_t e);
        int base;
        base = launch_cnt;
        pulse_start(e);
        wait_idle(name);
        check({name, "_launches"}, 64'(launch_cnt - base), 64'd4);
    endtask

    initial begin
        exp_t e;
        int   base;
        int   i;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_launch", 64'(launch), 64'd0);
        check("rst_valid", 64'(m_valid), 64'd0);
        check("rst_avg", 64'(m_avg), 64'd0);
        check("rst_min", 64'(m_min), 64'd0);
        check("rst_max", 64'(m_max), 64'd0);
        check("rst_ovf", 64'(m_ovf), 64'd0);
        check("rst_cycles", 64'(cycles), 64'd0);

        // Reset in the middle of a measurement (during SYNC1)
        start = 1'b1;
        tick();                 // now in LAUNCH
        start = 1'b0;
        check("mid_launch_hi", 64'(launch), 64'd1);
        tick();                 // now in SYNC1
        check("mid_busy_hi", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_launch", 64'(launch), 64'd0);
        check("mid_busy", 64'(busy), 64'd0);
        check("mid_valid", 64'(m_valid), 64'd0);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("mid_after_busy", 64'(busy), 64'd0);

        // Constant taps: lowest 16 taps set
        taps_const = 64'h0000_0000_0000_FFFF;
        repeat (2) tick();
        e = '{avg: 16, mn: 16, mx: 16, ovf: 0, lat: 19};
        run_meas("const16", e);

        // Per-launch codes 10, 20, 30, 41 (single-zero bubble patterns)
        taps_const = 64'h0;
        tap_q.push_back(~(64'd1 << 10));
        tap_q.push_back(~(64'd1 << 20));
        tap_q.push_back(~(64'd1 << 30));
        tap_q.push_back(~(64'd1 << 41));
        tick();
        e = '{avg: 25, mn: 10, mx: 41, ovf: 0, lat: 19};
        run_meas("seq", e);

        // Bubble pattern 0b11101111 -> code 4
        taps_const = 64'h0000_0000_0000_00EF;
        repeat (2) tick();
        e = '{avg: 4, mn: 4, mx: 4, ovf: 0, lat: 19};
        run_meas("bubble", e);

        // Backpressure: code 3, hold m_ready low for 10 cycles in DONE
        taps_const = 64'h0000_0000_0000_0007;
        m_ready = 1'b0;
        repeat (2) tick();
        base = launch_cnt;
        e = '{avg: 3, mn: 3, mx: 3, ovf: 0, lat: 19};
        pulse_start(e);
        for (i = 0; i < 100; i++) begin
            if (m_valid) break;
            tick();
        end
        if (i == 100) check("bp_valid_timeout", 64'd1, 64'd0);
        for (int k = 0; k < 10; k++) begin
            start = (k == 3);
            tick();
            check("bp_valid", 64'(m_valid), 64'd1);
            check("bp_busy", 64'(busy), 64'd1);
            check("bp_launch", 64'(launch), 64'd0);
            check("bp_avg", 64'(m_avg), 64'd3);
        end
        start   = 1'b0;
        m_ready = 1'b1;
        tick();
        check("bp_rel_valid", 64'(m_valid), 64'd0);
        check("bp_rel_busy", 64'(busy), 64'd0);
        check("bp_hold_avg", 64'(m_avg), 64'd3);
        check("bp_hold_max", 64'(m_max), 64'd3);
        repeat (3) tick();
        check("bp_launches", 64'(launch_cnt - base), 64'd4);
        check("bp_idle_busy", 64'(busy), 64'd0);

        // Saturation, single-sample instance
        taps1 = '1;
        sb1.push_back('{avg: 64, mn: 64, mx: 64, ovf: 1, lat: 4});
        start1     = 1'b1;
        start_cyc1 = tb_cyc + 1;
        tick();
        start1 = 1'b0;
        wait_idle("sat");

        // Counter on the default instance
        cnt_en = 1'b1;
        repeat (5) tick();
        cnt_en = 1'b0;
        tick();
        check("cnt32", 64'(cycles), 64'd5);

        // 8-bit counter wrap, clear priority, hold
        check("cnt8_start", 64'(cycles1), 64'd0);
        cnt_en1 = 1'b1;
        repeat (254) tick();
        check("cnt8_254", 64'(cycles1), 64'd254);
        tick();
        check("cnt8_255", 64'(cycles1), 64'd255);
        tick();
        check("cnt8_wrap", 64'(cycles1), 64'd0);
        tick();
        check("cnt8_1", 64'(cycles1), 64'd1);
        cnt_clr1 = 1'b1;
        tick();
        check("cnt8_clr", 64'(cycles1), 64'd0);
        cnt_clr1 = 1'b0;
        repeat (2) tick();
        check("cnt8_2", 64'(cycles1), 64'd2);
        cnt_en1 = 1'b0;
        repeat (3) tick();
        check("cnt8_hold", 64'(cycles1), 64'd2);

        repeat (3) tick();
        check("sb0_empty", 64'(sb0.size()), 64'd0);
        check("sb1_empty", 64'(sb1.size()), 64'd0);
        check("launch_width", 64'(wide_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/delay_tdc_sampler.md
Name: delay_tdc_sampler

Overview:
- Parametrised successor to the fixed 100-stage delay datapath.
- Controls an external chain of TAPS delay elements, instantiated in the parent as singlepath_plode stages.
- Per sample: launches a rising edge into the chain, captures the tap vector one clock later, double-synchronises it and thermometer-encodes it. Accumulates 2^SAMP_LOG2 samples and reports avg/min/max over a valid/ready handshake.
- Carries the free-running cycle counter, now with enable, clear and parametrised width.

Parameters:
TAPS, 64, number of chain taps observed (>=2)
SAMP_LOG2, 2, log2 of samples per measurement (0..8)
SETTLE, 1, extra drain cycles between samples with launch low (>=0)
CNT_W, 32, cycle counter width
CODE_W (derived), $clog2(TAPS+1), tap-code width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a measurement; sampled only in IDLE
busy  out  1  high in every state except IDLE
launch  out  1  drives chain input; high only in LAUNCH
taps  in  TAPS  chain tap outputs, tap0 nearest launch
m_valid  out  1  result valid
m_ready  in  1  result accepted when high with m_valid
m_avg  out  CODE_W  sum >> SAMP_LOG2 (truncating)
m_min  out  CODE_W  minimum sample code
m_max  out  CODE_W  maximum sample code
m_ovf  out  1  any sample saturated (all taps 1)
cnt_en  in  1  cycle counter increment enable
cnt_clr  in  1  synchronous counter clear
cycles  out  CNT_W  free-running cycle count

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; launch, busy, m_valid, m_ovf = 0; m_avg, m_min, m_max, cycles = 0; sync regs, accumulator, sample count = 0. Takes effect mid-operation immediately: launch drops in the same cycle, and any partial result is discarded.
- Tap pipeline runs free every cycle: r0<=taps, r1<=r0, r2<=r1.
- FSM states: IDLE, LAUNCH, SYNC1, SYNC2, ENC, DRAIN, DONE.
- IDLE: start=1 -> LAUNCH; clear acc=0, min=all-ones, max=0, ovf=0, n=0.
- LAUNCH (1 cycle, launch=1) -> SYNC1 -> SYNC2 -> ENC.
- ENC: r2 holds taps sampled at the end of LAUNCH.
  - code = index of the lowest tap equal to 0; if all taps are 1, code=TAPS and ovf is set. Bits above the first 0 (bubbles) are ignored.
  - acc += code; update min/max; n += 1.
  - If n reaches 2^SAMP_LOG2 -> DONE; else -> DRAIN, or LAUNCH directly if SETTLE=0.
- DRAIN: SETTLE cycles, then LAUNCH.
- Accumulator width is CODE_W+SAMP_LOG2, so it never overflows.
- Latency: start sampled at edge E0 -> m_valid high after edge E0 + (S-1)(4+SETTLE) + 4, where S=2^SAMP_LOG2. Defaults give 19.
- DONE: m_valid=1; m_avg/min/max/ovf registered on entry and held stable.
  - Stays in DONE while m_ready=0.
  - On m_ready=1 -> IDLE next cycle; m_valid and busy drop; result outputs keep their last values.
- start outside IDLE is ignored, with no queuing. start and m_ready in the same DONE cycle: start ignored.
- Cycle counter is independent of the FSM:
  - cnt_clr=1 -> 0 (clear beats enable).
  - else cnt_en=1 -> +1, wrapping from 2^CNT_W-1 to 0.

Test Plan:
- Reset mid-run: assert rst_n=0 during SYNC1 -> launch, busy, m_valid = 0 in the same cycle; after release, the next start gives a full clean measurement.
- Constant taps with the lowest 16 bits = 1 (defaults) -> m_valid 19 cycles after start; avg=min=max=16; ovf=0; launch pulsed 4 times, each 1 cycle wide.
- Per-sample tap codes 10, 20, 30, 41 (model switches on each launch) -> avg=25 (101>>2), min=10, max=41. Bubble pattern 0b...11101111 -> code 4.
- All 64 taps = 1 with SAMP_LOG2=0 -> m_max=64, m_ovf=1, m_valid after 4 cycles.
- Backpressure: hold m_ready=0 for 10 cycles in DONE and pulse start -> outputs stable, no new launch. Raise m_ready -> IDLE next cycle, busy=0.
- Counter with CNT_W=8: enable from 254 -> 255 -> 0. cnt_clr and cnt_en both high -> 0. cnt_en=0 -> value holds.
